// File: rtl/note_sequencer_if.sv
// note_sequencer_if: beat/play/ROM/note bundle between the score sequencer and its environment
// master: drives beat, play, rom_data; observes rom_addr, note, note_valid, done, busy
// slave:  the sequencer side of the same signals
interface note_sequencer_if #(
  parameter int AddrBits  = 6,
  parameter int PitchBits = 5,
  parameter int DurBits   = 3
);
  logic                         beat;
  logic                         play;
  logic [AddrBits-1:0]          rom_addr;
  logic [DurBits+PitchBits-1:0] rom_data;
  logic [PitchBits-1:0]         note;
  logic                         note_valid;
  logic                         done;
  logic                         busy;
  modport master (output beat, play, rom_data, input rom_addr, note, note_valid, done, busy);
  modport slave (input beat, play, rom_data, output rom_addr, note, note_valid, done, busy);
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a score ROM, holding each pitch for its beat count
// clk      : system clock, rising edge
// clear_n  : synchronous active-low reset
// bus      : slave side of note_sequencer_if (beat, play, rom_addr/rom_data, note, note_valid, done, busy)
module note_sequencer #(
  parameter int AddrBits  = 6,
  parameter int PitchBits = 5,
  parameter int DurBits   = 3,
  parameter bit Loop      = 1'b0
) (
  input logic              clk,
  input logic              clear_n,
  note_sequencer_if.slave  bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] END   = 3'd4;
  logic [2:0]           r_state;
  logic [AddrBits-1:0]  r_addr;
  logic [PitchBits-1:0] r_note;
  logic [DurBits-1:0]   r_rem;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_pend;
  logic [DurBits-1:0]   w_dur;
  logic [PitchBits-1:0] w_pitch;
  logic                 w_tick;
  assign {w_dur, w_pitch} = bus.rom_data;
  // a beat caught during the fetch counts as if it arrived on the first HOLD cycle
  assign w_tick = bus.play && (bus.beat || r_pend);
  assign bus.rom_addr   = r_addr;
  assign bus.note       = r_note;
  assign bus.note_valid = r_valid;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != IDLE) && (r_state != END);
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_note  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: r_state <= bus.play ? FETCH : IDLE;
        FETCH: begin
          r_pend  <= r_pend | bus.beat;
          r_state <= LOAD;
        end
        LOAD: begin
          if (w_dur == '0) begin
            r_done  <= 1'b1;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_pend  <= 1'b0;
            r_state <= Loop ? FETCH : END;
          end else begin
            r_pend  <= r_pend | bus.beat;
            r_note  <= w_pitch;
            r_rem   <= w_dur;
            r_valid <= (w_pitch != '0) && bus.play;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          r_pend  <= 1'b0;
          r_valid <= bus.play && (r_note != '0);
          if (w_tick) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == DurBits'(1)) begin
              r_addr  <= r_addr + 1'b1;
              r_state <= FETCH;
            end
          end
        end
        END: r_state <= bus.play ? END : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
